// File: rtl/random_gen_pkg.sv
// ============================================================================
//  Module : random_gen_pkg
//  Brief  : Shared defaults, state type and single-step LFSR function.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package random_gen_pkg;

   localparam int unsigned RG_DEFAULT_WIDTH = 8;
   localparam logic [RG_DEFAULT_WIDTH-1:0] RG_DEFAULT_TAPS = 8'hB8;

   typedef logic [RG_DEFAULT_WIDTH-1:0] rg_state_t;

   // One Fibonacci step: shift left, XOR of tapped bits enters at the LSB.
   function automatic rg_state_t lfsr_next(input rg_state_t state, input rg_state_t taps);
      return {state[RG_DEFAULT_WIDTH-2:0], ^(state & taps)};
   endfunction

endpackage

`default_nettype wire

// File: rtl/random_gen.sv
// ============================================================================
//  Module : random_gen
//  Brief  : Free-running WIDTH-bit Fibonacci LFSR, seed loaded during reset.
//           Optional macro RANDOM_GEN_ZERO_GUARD_EN keeps the state nonzero.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module random_gen
   import random_gen_pkg::*;
#(
   parameter int unsigned           WIDTH = RG_DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0]      TAPS  = WIDTH'(RG_DEFAULT_TAPS)
) (
   input  logic             clk,
   input  logic             rst_n,     // active-high despite the name
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] rand_out
);

   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] state_d;
   logic [WIDTH-1:0] w_load;
   logic             w_fb;

   assign w_fb = ^(state_q & TAPS);

`ifdef RANDOM_GEN_ZERO_GUARD_EN
   // All-zero is the LFSR's lock-up state; substitute 1 on load and on step.
   assign w_load  = (seed == '0) ? WIDTH'(1) : seed;
   assign state_d = (state_q == '0) ? WIDTH'(1) : {state_q[WIDTH-2:0], w_fb};
`else
   assign w_load  = seed;
   assign state_d = {state_q[WIDTH-2:0], w_fb};
`endif

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q <= w_load;
      end else begin
         state_q <= state_d;
      end
   end

   assign rand_out = state_q;

endmodule

`default_nettype wire

// File: tb/tb_random_gen.sv
// ============================================================================
//  Module : tb_random_gen
//  Brief  : Scoreboard bench for random_gen (8-bit default and 4-bit variant).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_random_gen;
   import random_gen_pkg::*;

   logic       clk = 1'b0;
   logic       rst8 = 1'b1;
   logic [7:0] seed8 = 8'hFF;
   logic [7:0] rand8;
   logic       rst4 = 1'b1;
   logic [3:0] seed4 = 4'h1;
   logic [3:0] rand4;

   always #5 clk = ~clk;

   random_gen u_dut8 (
      .clk      (clk),
      .rst_n    (rst8),
      .seed     (seed8),
      .rand_out (rand8)
   );

   random_gen #(.WIDTH(4), .TAPS(4'hC)) u_dut4 (
      .clk      (clk),
      .rst_n    (rst4),
      .seed     (seed4),
      .rand_out (rand4)
   );

   typedef struct {
      bit         dut4;
      logic [7:0] val;
      string      name;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] ev);
      n_checks++;
      if (act === ev) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, ev);
   endtask

   // Monitor: the DUT presents a value every cycle; compare against queued expectations.
   initial begin
      exp_t       e;
      logic [7:0] act;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = e.dut4 ? {4'b0, rand4} : rand8;
            check(e.name, {24'b0, act}, {24'b0, e.val});
         end
      end
   end

   task automatic step8(input logic r, input logic [7:0] s, input bit chk,
                        input logic [7:0] ev, input string nm);
      exp_t e;
      @(negedge clk);
      rst8  = r;
      seed8 = s;
      @(posedge clk);
      #1;
      if (chk) begin
         e.dut4 = 1'b0; e.val = ev; e.name = nm;
         exp_q.push_back(e);
      end
   endtask

   task automatic step4(input logic r, input logic [3:0] s, input logic [3:0] ev, input string nm);
      exp_t e;
      @(negedge clk);
      rst4  = r;
      seed4 = s;
      @(posedge clk);
      #1;
      e.dut4 = 1'b1; e.val = {4'b0, ev}; e.name = nm;
      exp_q.push_back(e);
   endtask

   function automatic logic [3:0] next4(input logic [3:0] s);
      return {s[2:0], ^(s & 4'hC)};
   endfunction

   initial begin
      rg_state_t  m;
      logic [3:0] m4;
      bit         seen[256];
      bit         seen4[16];
      int         distinct;
      int         zeros;
      int         drain;

      // Reset with seed FF then hand-computed sequence.
      step8(1'b1, 8'hFF, 1'b1, 8'hFF, "rst_ff_edge0");
      step8(1'b1, 8'hFF, 1'b1, 8'hFF, "rst_ff_edge1");
      step8(1'b0, 8'hFF, 1'b1, 8'hFE, "seq_fe");
      step8(1'b0, 8'hFF, 1'b1, 8'hFC, "seq_fc");
      step8(1'b0, 8'hFF, 1'b1, 8'hF8, "seq_f8");
      step8(1'b0, 8'hFF, 1'b1, 8'hF0, "seq_f0");
      step8(1'b0, 8'hFF, 1'b1, 8'hE1, "seq_e1");
      m = 8'hE1;

      // Seed change while running must not disturb the sequence.
      for (int i = 0; i < 6; i++) begin
         m = lfsr_next(m, RG_DEFAULT_TAPS);
         step8(1'b0, 8'h5A, 1'b1, m, "seed_change_ignored");
      end
      step8(1'b1, 8'h5A, 1'b1, 8'h5A, "rst_5a");
      step8(1'b0, 8'h5A, 1'b1, 8'hB4, "succ_b4");
      m = 8'hB4;

      // Single-edge reset mid-sequence.
      for (int i = 0; i < 5; i++) begin
         m = lfsr_next(m, RG_DEFAULT_TAPS);
         step8(1'b0, 8'hC3, 1'b1, m, "pre_mid_rst");
      end
      step8(1'b1, 8'hC3, 1'b1, 8'hC3, "mid_rst_seed");
      m = 8'hC3;
      for (int i = 0; i < 10; i++) begin
         m = lfsr_next(m, RG_DEFAULT_TAPS);
         step8(1'b0, 8'hC3, 1'b1, m, "post_mid_rst");
      end

      // Full period from seed 01.
      step8(1'b1, 8'h01, 1'b1, 8'h01, "rst_01");
      m = 8'h01;
      foreach (seen[i]) seen[i] = 1'b0;
      distinct = 0;
      zeros    = 0;
      for (int i = 1; i <= 255; i++) begin
         m = lfsr_next(m, RG_DEFAULT_TAPS);
         step8(1'b0, 8'h01, 1'b1, m, "period_seq");
         if (rand8 == 8'h00) zeros++;
         if (!seen[rand8]) begin
            seen[rand8] = 1'b1;
            distinct++;
         end
      end
      check("period_distinct", distinct, 255);
      check("period_no_zero", zeros, 0);
      check("period_return_01", {24'b0, rand8}, 32'h01);

      // Zero seed: locks at zero unless the guard is built in.
`ifdef RANDOM_GEN_ZERO_GUARD_EN
      step8(1'b1, 8'h00, 1'b1, 8'h01, "zg_rst_01");
      step8(1'b0, 8'h00, 1'b1, 8'h02, "zg_02");
      step8(1'b0, 8'h00, 1'b1, 8'h04, "zg_04");
      step8(1'b0, 8'h00, 1'b1, 8'h08, "zg_08");
      step8(1'b0, 8'h00, 1'b1, 8'h11, "zg_11");
`else
      step8(1'b1, 8'h00, 1'b1, 8'h00, "zero_rst");
      for (int i = 0; i < 20; i++) step8(1'b0, 8'h00, 1'b1, 8'h00, "zero_lock");
`endif

      // 4-bit variant, taps C, seed 1: period 15.
      step4(1'b1, 4'h1, 4'h1, "w4_rst");
      m4 = 4'h1;
      foreach (seen4[i]) seen4[i] = 1'b0;
      distinct = 0;
      for (int i = 1; i <= 15; i++) begin
         m4 = next4(m4);
         step4(1'b0, 4'h1, m4, "w4_seq");
         if (!seen4[rand4]) begin
            seen4[rand4] = 1'b1;
            distinct++;
         end
      end
      check("w4_distinct", distinct, 15);
      check("w4_zero_unseen", {31'b0, seen4[0]}, 0);
      check("w4_return_1", {28'b0, rand4}, 32'h1);

      drain = 0;
      while (exp_q.size() > 0 && drain < 10) begin
         @(posedge clk);
         drain++;
      end
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
